// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: arbitrates HPB/FIFO, issues frames to the bit-stream layer, handles retry, drop and timeout
module can_tx_scheduler #(
  parameter int MAX_RETRY = 8,
  parameter int TIMEOUT = 4095,
  parameter int RETRY_GAP = 3
) (
  input  logic         sys_clk,
  input  logic         IP2Can_reset,
  input  logic         mode_normal,
  input  logic [5:0]   fifo_count,
  input  logic [127:0] fifo_msg,
  input  logic         hpb_full,
  input  logic [127:0] hpb_msg,
  input  logic         TXOK,
  input  logic         ARBLST,
  input  logic         tx_error,
  output logic [127:0] tx_message,
  output logic         tx_en,
  output logic         deload_fifo,
  output logic         deload_hpb,
  output logic         tx_src,
  output logic         tx_done,
  output logic         tx_abort,
  output logic [3:0]   retry_cnt,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RETRY, DONE} state_t;
  state_t state;
  logic [15:0] timer;
  logic [7:0] gap;
  logic fail;
  logic [3:0] next_cnt;
  assign fail = tx_error | ARBLST | (timer == 16'(TIMEOUT - 1));
  assign next_cnt = retry_cnt + 4'd1;
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset) begin
      state <= IDLE;
      tx_message <= '0;
      tx_en <= 1'b0;
      deload_fifo <= 1'b0;
      deload_hpb <= 1'b0;
      tx_src <= 1'b0;
      tx_done <= 1'b0;
      tx_abort <= 1'b0;
      retry_cnt <= '0;
      busy <= 1'b0;
      timer <= '0;
      gap <= '0;
    end else begin
      deload_fifo <= 1'b0;
      deload_hpb <= 1'b0;
      tx_done <= 1'b0;
      tx_abort <= 1'b0;
      case (state)
        IDLE: if (mode_normal && (hpb_full || fifo_count != 6'd0)) begin
          tx_message <= hpb_full ? hpb_msg : fifo_msg;
          tx_src <= hpb_full;
          // a different source means the previous failed message was preempted
          if (hpb_full != tx_src) retry_cnt <= '0;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          tx_en <= 1'b1;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: if (TXOK) begin
          tx_en <= 1'b0;
          deload_hpb <= tx_src;
          deload_fifo <= ~tx_src;
          tx_done <= 1'b1;
          state <= DONE;
        end else if (fail) begin
          tx_en <= 1'b0;
          retry_cnt <= next_cnt;
          if (next_cnt == 4'(MAX_RETRY)) begin
            deload_hpb <= tx_src;
            deload_fifo <= ~tx_src;
            tx_abort <= 1'b1;
            state <= DONE;
          end else begin
            gap <= '0;
            state <= RETRY;
          end
        end else timer <= timer + 16'd1;
        RETRY: if (gap == 8'(RETRY_GAP - 1)) begin
          busy <= 1'b0;
          state <= IDLE;
        end else gap <= gap + 8'd1;
        DONE: begin
          // lets the served source update its flag/count before re-arbitration
          retry_cnt <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb_can_tx_scheduler: randomized transaction-level check of can_tx_scheduler against a source/retry model
module tb_can_tx_scheduler;
  localparam int MAXR = 3, TMO = 16, GAP = 3;
  logic sys_clk, IP2Can_reset, mode_normal, hpb_full, TXOK, ARBLST, tx_error;
  logic [5:0] fifo_count;
  logic [127:0] fifo_msg, hpb_msg, tx_message;
  logic tx_en, deload_fifo, deload_hpb, tx_src, tx_done, tx_abort, busy;
  logic [3:0] retry_cnt;
  logic [127:0] q[$];
  int cnt[2];
  int checks, errors, nlat;
  bit allow_dl;

  can_tx_scheduler #(.MAX_RETRY(MAXR), .TIMEOUT(TMO), .RETRY_GAP(GAP)) dut (
    .sys_clk(sys_clk), .IP2Can_reset(IP2Can_reset), .mode_normal(mode_normal),
    .fifo_count(fifo_count), .fifo_msg(fifo_msg), .hpb_full(hpb_full), .hpb_msg(hpb_msg),
    .TXOK(TXOK), .ARBLST(ARBLST), .tx_error(tx_error), .tx_message(tx_message),
    .tx_en(tx_en), .deload_fifo(deload_fifo), .deload_hpb(deload_hpb), .tx_src(tx_src),
    .tx_done(tx_done), .tx_abort(tx_abort), .retry_cnt(retry_cnt), .busy(busy));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic upd();
    fifo_count = 6'(q.size());
    fifo_msg = q.size() != 0 ? q[0] : '0;
  endtask

  task automatic push();
    q.push_back({$urandom, $urandom, $urandom, $urandom});
    upd();
  endtask

  task automatic set_hpb();
    hpb_full = 1'b1;
    hpb_msg = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (!allow_dl) check("no_deload", 128'({deload_hpb, deload_fifo}), 128'(0));
    if (deload_fifo && q.size() != 0) void'(q.pop_front());
    if (deload_hpb) hpb_full = 1'b0;
    upd();
  endtask

  // resp: 0 TXOK, 1 tx_error, 2 ARBLST, 3 TXOK+ARBLST, 4 no response, 5 reset
  task automatic run_attempt(input int resp, input int dly, input bit mid);
    int s;
    logic [127:0] m;
    s = hpb_full ? 1 : 0;
    m = hpb_full ? hpb_msg : q[0];
    cnt[1 - s] = 0;
    for (int i = 1; i <= nlat; i++) begin
      tick();
      if (i < nlat) check("pre_en", 128'(tx_en), 128'(0));
    end
    check("en_rise", 128'(tx_en), 128'(1));
    check("msg", tx_message, m);
    check("src", 128'(tx_src), 128'(s));
    check("retry_issue", 128'(retry_cnt), 128'(cnt[s]));
    check("busy", 128'(busy), 128'(1));
    if (mid) begin
      mode_normal = 1'b0;
      if (!hpb_full) set_hpb();
      else if (q.size() < 60) push();
    end
    for (int i = 0; i < (resp == 4 ? TMO - 1 : dly); i++) begin
      tick();
      check("wait_en", 128'(tx_en), 128'(1));
    end
    mode_normal = 1'b1;
    TXOK = resp == 0 || resp == 3;
    tx_error = resp == 1;
    ARBLST = resp == 2 || resp == 3;
    IP2Can_reset = resp == 5;
    allow_dl = resp != 5;
    tick();
    allow_dl = 1'b0;
    {TXOK, tx_error, ARBLST, IP2Can_reset} = '0;
    if (resp == 5) begin
      check("rst_out", {tx_message, 10'(tx_en), 10'(tx_src), 10'(tx_done), 10'(tx_abort),
            10'(retry_cnt), 10'(busy)}, '0);
      cnt[0] = 0;
      cnt[1] = 0;
      nlat = 2;
    end else begin
      check("en_drop", 128'(tx_en), 128'(0));
      check("busy_out", 128'(busy), 128'(1));
      if (resp == 0 || resp == 3) begin
        check("done", 128'({tx_done, tx_abort}), 128'(2'b10));
        check("deload_ok", 128'({deload_hpb, deload_fifo}), 128'(s ? 2'b10 : 2'b01));
        check("retry_ok", 128'(retry_cnt), 128'(cnt[s]));
        cnt[s] = 0;
        nlat = 3;
      end else begin
        cnt[s]++;
        check("retry_fail", 128'(retry_cnt), 128'(cnt[s]));
        if (cnt[s] == MAXR) begin
          check("abort", 128'({tx_done, tx_abort}), 128'(2'b01));
          check("deload_drop", 128'({deload_hpb, deload_fifo}), 128'(s ? 2'b10 : 2'b01));
          cnt[s] = 0;
          nlat = 3;
        end else begin
          check("no_pulse", 128'({tx_done, tx_abort, deload_hpb, deload_fifo}), 128'(0));
          nlat = GAP + 2;
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cnt[0] = 0;
    cnt[1] = 0;
    allow_dl = 1'b0;
    IP2Can_reset = 1'b1;
    {mode_normal, hpb_full, TXOK, ARBLST, tx_error} = '0;
    hpb_msg = '0;
    upd();
    tick();
    tick();
    check("reset", {tx_message, 10'(tx_en), 10'(deload_fifo), 10'(deload_hpb), 10'(tx_src),
          10'(tx_done), 10'(tx_abort), 10'(retry_cnt), 10'(busy)}, '0);
    IP2Can_reset = 1'b0;
    set_hpb();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("mode_off", 128'({tx_en, busy}), 128'(0));
    end
    mode_normal = 1'b1;
    nlat = 2;
    run_attempt(0, 3, 0);
    for (int i = 0; i < 3; i++) tick();
    check("idle", 128'(busy), 128'(0));
    q.push_back(128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A501);
    upd();
    nlat = 2;
    run_attempt(0, 5, 0);
    set_hpb();
    for (int i = 0; i < 3; i++) push();
    run_attempt(0, 2, 0);
    run_attempt(2, 1, 0);
    run_attempt(2, 4, 0);
    set_hpb();
    run_attempt(0, 0, 0);
    run_attempt(0, 3, 0);
    run_attempt(1, 2, 0);
    run_attempt(1, 0, 0);
    run_attempt(1, 6, 0);
    run_attempt(4, 0, 0);
    run_attempt(3, 2, 0);
    push();
    run_attempt(5, 4, 0);
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 19);
      run_attempt(r == 19 ? 5 : r % 5, $urandom_range(0, 10), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0 && q.size() < 60) push();
      if (!hpb_full && $urandom_range(0, 4) == 0) set_hpb();
      if (!hpb_full && q.size() == 0) push();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
Sequences transmission from the two TX storage sources, the TX high-priority buffer (HPB) and the TX FIFO, to the bit-stream layer. It selects the source, latches the 128-bit message, and drives tx_en. It then waits for TXOK, arbitration loss or error, and returns a one-cycle deload pulse to the source that was served. It also handles retry, drop-after-N-retries and a watchdog timeout. It sits between Tx_storage_FIFO/Tx_storage_HPB and the protocol engine, and replaces fixed priority muxing.

Parameters:
MAX_RETRY, 8, failed attempts (ARBLST/error/timeout) before the message is dropped; range 1..15.
TIMEOUT, 4095, cycles in WAIT with no TXOK/ARBLST/tx_error before the attempt counts as failed; range 1..65535.
RETRY_GAP, 3, idle cycles in RETRY before re-arbitration; range 1..255.

Ports:
sys_clk  in  1  system clock, all logic on rising edge
IP2Can_reset  in  1  synchronous, active-high reset
mode_normal  in  1  controller in NORMAL mode; new transmissions start only when high
fifo_count  in  6  TX FIFO occupancy (count1); non-zero means a message is available
fifo_msg  in  128  TX FIFO head message (txfifo_op)
hpb_full  in  1  TX HPB holds a message (TXBFLL)
hpb_msg  in  128  TX HPB message (txhpb_op)
TXOK  in  1  frame transmitted successfully (pulse)
ARBLST  in  1  arbitration lost (pulse)
tx_error  in  1  bus error during the frame (pulse)
tx_message  out  128  latched message presented to the bit-stream layer
tx_en  out  1  request to transmit tx_message
deload_fifo  out  1  one-cycle pop of the TX FIFO
deload_hpb  out  1  one-cycle clear of the TX HPB
tx_src  out  1  source of the current attempt: 1=HPB, 0=FIFO
tx_done  out  1  one-cycle pulse on successful completion
tx_abort  out  1  one-cycle pulse when a message is dropped after MAX_RETRY failures
retry_cnt  out  4  failed attempts for the current message
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset (IP2Can_reset=1 at a clock edge) forces state=IDLE, tx_message=0, and tx_en, deload_*, tx_src, tx_done, tx_abort, busy = 0, retry_cnt=0, timer=0, gap counter=0. Reset has priority over every event and aborts any attempt mid-operation with no deload pulse.
- States: IDLE, ISSUE, WAIT, RETRY, DONE (binary encoding).
- IDLE:
  - Starts only if mode_normal=1 and (hpb_full=1 or fifo_count!=0).
  - HPB has strict priority over FIFO.
  - On start: latch tx_message from the selected source and set tx_src. If the selected source differs from the tx_src of the previous failed attempt (HPB preempted a FIFO retry), clear retry_cnt. Go to ISSUE.
- ISSUE: assert tx_en=1, clear timer, go to WAIT. tx_en rises 2 cycles after the request is seen in IDLE.
- WAIT:
  - tx_en stays 1; timer increments each cycle. Events are evaluated in priority order TXOK > tx_error > ARBLST > timeout (timer==TIMEOUT-1).
  - TXOK: tx_en=0; pulse deload_hpb or deload_fifo (per tx_src) and tx_done in the same cycle; go to DONE.
  - Failure (tx_error, ARBLST or timeout): tx_en=0; retry_cnt increments.
    - If the new retry_cnt==MAX_RETRY: pulse deload of the source and tx_abort; go to DONE.
    - Otherwise go to RETRY.
  - mode_normal dropping during WAIT is ignored; the frame completes.
- RETRY: tx_en=0; count RETRY_GAP cycles, then go to IDLE. The message is not deloaded; IDLE re-arbitrates, so a newly full HPB preempts the FIFO retry.
- DONE: one cycle; clear retry_cnt and go to IDLE. This cycle guarantees the source's count/flag has updated before the next arbitration, so no message is issued twice.
- tx_message is held stable from ISSUE until the next latch in IDLE. It is not altered by source changes during WAIT.
- Exactly one deload pulse is issued per completed or dropped message; none on reset, RETRY or preemption.
- fifo_count is treated only as zero/non-zero; full/empty handling stays in the FIFO.

Test Plan:
1. Reset, then fifo_count=1, fifo_msg=128'hA5…01, mode_normal=1; TXOK 5 cycles after tx_en rises -> tx_en high 2 cycles after request; tx_message=fifo_msg, tx_src=0; deload_fifo and tx_done pulse once; retry_cnt=0.
2. hpb_full=1 and fifo_count=3 simultaneously -> HPB served first (tx_src=1, deload_hpb); FIFO issued after the DONE cycle.
3. FIFO message gets ARBLST twice, then HPB becomes full during RETRY -> retry_cnt=2, then cleared; HPB sent; the FIFO message follows with retry_cnt starting at 0; deload_fifo not pulsed on ARBLST.
4. MAX_RETRY=3, tx_error every attempt -> third failure gives tx_abort + deload_fifo; retry_cnt=3 then 0; tx_done never pulses.
5. TIMEOUT=16, no response -> tx_en drops after 16 WAIT cycles and retry_cnt=1. TXOK and ARBLST in the same cycle -> treated as success.
6. IP2Can_reset asserted mid-WAIT -> next cycle all outputs 0, state IDLE, no deload. With mode_normal=0 and hpb_full=1 -> no tx_en.
